wb_cmd_master: RTL and testbench
================================

Name: wb_cmd_master

Overview:
Downstream of the multi-cycle CPU. Consumes the 34-bit command stream (cmd_stb/cmd_word/cmd_busy) and returns 34-bit responses (rsp_stb/rsp_word). Runs one pipelined-Wishbone (B4) single-beat transaction per read/write command against instruction/data memory. Keeps an internal word-address register with optional post-increment, so the CPU issues "set address" once and then streams reads/writes.

Parameters:
AW, 30, Wishbone word-address width (must be 30 for the command encoding)
DW, 32, data width
TIMEOUT, 255, max cycles a bus transaction may wait for ack/err before abort (0 = no timeout)

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-low reset
cmd_stb  in  1  command valid
cmd_word  in  34  command: [33:32] opcode, [31:0] payload
cmd_busy  out  1  high = command not accepted this cycle
rsp_stb  out  1  one-cycle response valid pulse
rsp_word  out  34  response: [33:32] code, [31:0] data
o_wb_cyc  out  1  Wishbone cycle
o_wb_stb  out  1  Wishbone strobe
o_wb_we  out  1  write enable
o_wb_addr  out  30  word address
o_wb_data  out  32  write data
o_wb_sel  out  4  byte selects, always 4'hF
i_wb_stall  in  1  slave stall
i_wb_ack  in  1  slave ack
i_wb_err  in  1  slave error
i_wb_data  in  32  read data

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-low on port reset. While low: all outputs 0, except o_wb_sel = 4'hF. addr_reg = 0, inc_en = 1, timeout counter = 0, state IDLE.
- Command accepted on a rising edge with cmd_stb && !cmd_busy. cmd_busy = (state != IDLE). Commands presented while busy are ignored; the CPU holds them.
- Opcode 2'b00 READ: bus read at addr_reg.
- Opcode 2'b01 WRITE: bus write of cmd_word[31:0] at addr_reg.
- Opcode 2'b10 SETADDR: addr_reg <= cmd_word[29:0]; inc_en <= !cmd_word[30]; bit 31 ignored. No bus cycle. rsp_stb at the next cycle with {2'b10, 2'b00, new addr}. cmd_busy stays low, so back-to-back commands are allowed.
- Opcode 2'b11 is illegal: no bus cycle; rsp {2'b11, 32'h0} at the next cycle.
- State machine: IDLE -> REQ -> WAIT -> IDLE.
  - IDLE: on accepted READ/WRITE, load o_wb_addr/o_wb_we/o_wb_data and enter REQ next edge.
  - REQ: cyc=stb=1. Leave to WAIT on the edge where !i_wb_stall; stb drops then, cyc stays high.
  - WAIT: cyc=1, stb=0.
- An ack or err sampled in REQ (same cycle as stb accepted) is honoured; the FSM goes directly to IDLE.
- On ack: next cycle cyc=0, state IDLE, rsp_stb=1.
  - READ response: {2'b00, i_wb_data} (data registered at the ack edge).
  - WRITE response: {2'b01, 32'h0}.
  - addr_reg increments by 1 if inc_en; wraps 30'h3FFFFFFF -> 0.
- On err, or ack and err together (err wins): rsp {2'b11, 32'h0}; addr_reg not incremented.
- Timeout: counter clears on entering REQ and counts in REQ/WAIT. When it reaches TIMEOUT: drop cyc/stb, return to IDLE, emit rsp {2'b11, 32'h1}, no increment. Late acks arriving while cyc=0 are ignored.
- Minimum latency, READ/WRITE: accept edge N; stb high N+1; zero-wait ack at N+2 sample; rsp_stb high cycle N+3; cmd_busy low again cycle N+3.
- rsp_stb is exactly one cycle; rsp_word holds its value until the next response.
- Reset asserted mid-transaction: cyc/stb drop immediately (async); no response is issued.

Decomposition:
- Shared package wb_cmd_pkg:
  - command opcodes CMD_RD=2'b00, CMD_WR=2'b01, CMD_ADDR=2'b10, CMD_BAD=2'b11
  - response codes RSP_RD, RSP_WR, RSP_ADDR, RSP_ERR
  - bit positions: opcode [33:32], inc-disable bit 30, address [29:0]
  - FSM state encoding
  - the CPU's command builder uses the same package
- One sub-module: wb_timeout_ctr (clear/enable/expire, TIMEOUT parameter).

Test Plan:
- SETADDR 34'h2_4000_0010 then READ; slave acks with 32'hDEADBEEF and stall=0 -> rsp 34'h2_0000_0010, then o_wb_addr=30'h10, rsp 34'h0_DEADBEEF at N+3; addr_reg stays 0x10 (increment disabled).
- SETADDR 34'h2_0000_0020, then WRITE 34'h1_CAFEF00D x3 with 2 stall cycles each -> o_wb_addr 0x20, 0x21, 0x22; o_wb_we=1, o_wb_data=32'hCAFEF00D; three rsp 34'h1_00000000; stb held through stall.
- SETADDR to 30'h3FFFFFFF with increment, then 2 READs -> o_wb_addr 0x3FFFFFFF then 0x0 (wrap).
- READ answered with i_wb_err (and once with ack+err together) -> rsp 34'h3_00000000, addr_reg unchanged, cyc low next cycle.
- TIMEOUT=8, slave never acks -> cyc drops 8 cycles after REQ entry, rsp 34'h3_00000001; an ack injected 3 cycles later produces no response.
- Reset pulled low while in WAIT -> cyc/stb/cmd_busy/rsp_stb low immediately; after release, SETADDR then READ work normally from addr 0.

Source files
------------

// File: rtl/wb_cmd_pkg.sv
// Shared definitions for the CPU command stream and the Wishbone command master.
// The CPU-side command builder uses mk_cmd() so both ends agree on the encoding.
package wb_cmd_pkg;

   localparam int CMD_W       = 34;
   localparam int OP_MSB      = 33;
   localparam int OP_LSB      = 32;
   localparam int INC_DIS_BIT = 30;
   localparam int ADDR_MSB    = 29;

   typedef enum logic [1:0] {
      CMD_RD   = 2'b00,
      CMD_WR   = 2'b01,
      CMD_ADDR = 2'b10,
      CMD_BAD  = 2'b11
   } cmd_op_e;

   typedef enum logic [1:0] {
      RSP_RD   = 2'b00,
      RSP_WR   = 2'b01,
      RSP_ADDR = 2'b10,
      RSP_ERR  = 2'b11
   } rsp_code_e;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_WAIT = 2'd2
   } wb_state_e;

   function automatic logic [CMD_W-1:0] mk_cmd(input cmd_op_e op, input logic [31:0] payload);
      return {op, payload};
   endfunction

endpackage

// File: rtl/wb_timeout_ctr.sv
// Bus-transaction watchdog: reloaded on clear, counts down while enabled,
// expires on the last allowed cycle. TIMEOUT = 0 disables it.
module wb_timeout_ctr #(
   parameter int TIMEOUT = 255
) (
   input  logic clk,
   input  logic rst_b,
   input  logic clr_i,
   input  logic en_i,
   output logic expire_o
);

   localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

   logic [CW-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = CW'(TIMEOUT);
      end else if (en_i && (cnt_q != '0)) begin
         cnt_d = cnt_q - CW'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   // Terminal count of 1: the abort edge is the TIMEOUT-th edge after REQ entry.
   assign expire_o = (TIMEOUT != 0) && en_i && (cnt_q == CW'(1));

endmodule

// File: rtl/wb_cmd_master.sv
// Turns the CPU command stream into single-beat pipelined Wishbone transactions.
//   state   | meaning
//   IDLE    | ready for a command; SETADDR / illegal answered here
//   REQ     | cyc=stb=1, waiting for the slave to take the strobe
//   WAIT    | cyc=1, stb=0, waiting for ack/err or timeout
module wb_cmd_master
   import wb_cmd_pkg::*;
#(
   parameter int AW      = 30,
   parameter int DW      = 32,
   parameter int TIMEOUT = 255
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             cmd_stb,
   input  logic [CMD_W-1:0] cmd_word,
   output logic             cmd_busy,
   output logic             rsp_stb,
   output logic [CMD_W-1:0] rsp_word,
   output logic             o_wb_cyc,
   output logic             o_wb_stb,
   output logic             o_wb_we,
   output logic [AW-1:0]    o_wb_addr,
   output logic [DW-1:0]    o_wb_data,
   output logic [3:0]       o_wb_sel,
   input  logic             i_wb_stall,
   input  logic             i_wb_ack,
   input  logic             i_wb_err,
   input  logic [DW-1:0]    i_wb_data
);

   wb_state_e        state_q, state_d;
   logic [AW-1:0]    addr_reg_q, addr_reg_d;
   logic             inc_en_q, inc_en_d;
   logic [AW-1:0]    wb_addr_q, wb_addr_d;
   logic             wb_we_q, wb_we_d;
   logic [DW-1:0]    wb_data_q, wb_data_d;
   logic             rsp_stb_q, rsp_stb_d;
   logic [CMD_W-1:0] rsp_word_q, rsp_word_d;
   logic             tmo_clr, tmo_en, tmo_expire;
   cmd_op_e          cmd_op;

   assign cmd_op = cmd_op_e'(cmd_word[OP_MSB:OP_LSB]);
   assign tmo_en = (state_q != ST_IDLE);

   wb_timeout_ctr #(
      .TIMEOUT (TIMEOUT)
   ) u_tmo (
      .clk      (clk),
      .rst_b    (reset),
      .clr_i    (tmo_clr),
      .en_i     (tmo_en),
      .expire_o (tmo_expire)
   );

   always_comb begin
      state_d    = state_q;
      addr_reg_d = addr_reg_q;
      inc_en_d   = inc_en_q;
      wb_addr_d  = wb_addr_q;
      wb_we_d    = wb_we_q;
      wb_data_d  = wb_data_q;
      rsp_stb_d  = 1'b0;
      rsp_word_d = rsp_word_q;
      tmo_clr    = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (cmd_stb) begin
               case (cmd_op)
                  CMD_RD: begin
                     wb_addr_d = addr_reg_q;
                     wb_we_d   = 1'b0;
                     tmo_clr   = 1'b1;
                     state_d   = ST_REQ;
                  end
                  CMD_WR: begin
                     wb_addr_d = addr_reg_q;
                     wb_we_d   = 1'b1;
                     wb_data_d = cmd_word[DW-1:0];
                     tmo_clr   = 1'b1;
                     state_d   = ST_REQ;
                  end
                  CMD_ADDR: begin
                     addr_reg_d = cmd_word[ADDR_MSB:0];
                     inc_en_d   = !cmd_word[INC_DIS_BIT];
                     rsp_stb_d  = 1'b1;
                     rsp_word_d = {RSP_ADDR, 2'b00, cmd_word[ADDR_MSB:0]};
                  end
                  default: begin
                     rsp_stb_d  = 1'b1;
                     rsp_word_d = {RSP_ERR, 32'h0};
                  end
               endcase
            end
         end
         ST_REQ, ST_WAIT: begin
            // A slave answer on the final allowed cycle beats the watchdog.
            if (i_wb_err) begin
               rsp_stb_d  = 1'b1;
               rsp_word_d = {RSP_ERR, 32'h0};
               state_d    = ST_IDLE;
            end else if (i_wb_ack) begin
               rsp_stb_d  = 1'b1;
               rsp_word_d = wb_we_q ? {RSP_WR, 32'h0} : {RSP_RD, i_wb_data};
               if (inc_en_q) begin
                  addr_reg_d = addr_reg_q + AW'(1);
               end
               state_d = ST_IDLE;
            end else if (tmo_expire) begin
               rsp_stb_d  = 1'b1;
               rsp_word_d = {RSP_ERR, 32'h1};
               state_d    = ST_IDLE;
            end else if ((state_q == ST_REQ) && !i_wb_stall) begin
               state_d = ST_WAIT;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q    <= ST_IDLE;
         addr_reg_q <= '0;
         inc_en_q   <= 1'b1;
         wb_addr_q  <= '0;
         wb_we_q    <= 1'b0;
         wb_data_q  <= '0;
         rsp_stb_q  <= 1'b0;
         rsp_word_q <= '0;
      end else begin
         state_q    <= state_d;
         addr_reg_q <= addr_reg_d;
         inc_en_q   <= inc_en_d;
         wb_addr_q  <= wb_addr_d;
         wb_we_q    <= wb_we_d;
         wb_data_q  <= wb_data_d;
         rsp_stb_q  <= rsp_stb_d;
         rsp_word_q <= rsp_word_d;
      end
   end

   assign cmd_busy  = (state_q != ST_IDLE);
   assign o_wb_cyc  = (state_q != ST_IDLE);
   assign o_wb_stb  = (state_q == ST_REQ);
   assign o_wb_we   = wb_we_q;
   assign o_wb_addr = wb_addr_q;
   assign o_wb_data = wb_data_q;
   assign o_wb_sel  = 4'hF;
   assign rsp_stb   = rsp_stb_q;
   assign rsp_word  = rsp_word_q;

endmodule

// File: tb/tb_wb_cmd_master.sv
// Bench for wb_cmd_master: directed vector table, hand-written corner sequences,
// and random commands checked against a command-level reference model.
module tb_wb_cmd_master;
   import wb_cmd_pkg::*;

   localparam int TMO    = 8;
   localparam int K_ACK  = 0;
   localparam int K_ERR  = 1;
   localparam int K_BOTH = 2;
   localparam int K_NONE = 3;

   logic        clk = 1'b0;
   logic        reset;
   logic        cmd_stb;
   logic [33:0] cmd_word;
   logic        cmd_busy;
   logic        rsp_stb;
   logic [33:0] rsp_word;
   logic        o_wb_cyc, o_wb_stb, o_wb_we;
   logic [29:0] o_wb_addr;
   logic [31:0] o_wb_data;
   logic [3:0]  o_wb_sel;
   logic        i_wb_stall, i_wb_ack, i_wb_err;
   logic [31:0] i_wb_data;

   int n_tests = 0;
   int n_fail  = 0;

   logic [29:0] m_addr;
   logic        m_inc;

   wb_cmd_master #(.AW(30), .DW(32), .TIMEOUT(TMO)) dut (
      .clk        (clk),
      .reset      (reset),
      .cmd_stb    (cmd_stb),
      .cmd_word   (cmd_word),
      .cmd_busy   (cmd_busy),
      .rsp_stb    (rsp_stb),
      .rsp_word   (rsp_word),
      .o_wb_cyc   (o_wb_cyc),
      .o_wb_stb   (o_wb_stb),
      .o_wb_we    (o_wb_we),
      .o_wb_addr  (o_wb_addr),
      .o_wb_data  (o_wb_data),
      .o_wb_sel   (o_wb_sel),
      .i_wb_stall (i_wb_stall),
      .i_wb_ack   (i_wb_ack),
      .i_wb_err   (i_wb_err),
      .i_wb_data  (i_wb_data)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [1:0]  op;
      logic [31:0] pay;
      int          s;
      int          w;
      int          kind;
      logic [31:0] rd;
      logic [29:0] addr;
      logic [33:0] rsp;
      int          lat;
   } vec_t;

   vec_t tbl[17];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
      end
   endtask

   // Command-level model: response, bus address and cycles from accept to rsp_stb.
   task automatic model_step(input logic [1:0] op, input logic [31:0] pay, input int s,
                             input int w, input int kind, input logic [31:0] rd,
                             output logic [29:0] ea, output logic [33:0] er, output int lat);
      ea = m_addr;
      if (op == 2'b10) begin
         m_addr = pay[29:0];
         m_inc  = ~pay[30];
         er     = {2'b10, 2'b00, pay[29:0]};
         lat    = 0;
      end else if (op == 2'b11) begin
         er  = {2'b11, 32'h0};
         lat = 0;
      end else if (kind == K_NONE || s + w >= TMO) begin
         er  = {2'b11, 32'h1};
         lat = TMO;
      end else begin
         lat = s + w + 1;
         if (kind == K_ACK) begin
            er = (op == 2'b00) ? {2'b00, rd} : {2'b01, 32'h0};
            if (m_inc) m_addr = (m_addr == 30'h3FFFFFFF) ? 30'h0 : m_addr + 30'h1;
         end else begin
            er = {2'b11, 32'h0};
         end
      end
   endtask

   // Issues one command and plays the slave; starts and ends on a falling edge.
   task automatic run_cmd(input string tag, input logic [1:0] op, input logic [31:0] pay,
                          input int s, input int w, input int kind, input logic [31:0] rd,
                          input logic [29:0] ea, input logic [33:0] er, input int lat);
      int          got;
      logic [33:0] got_rsp;
      bit          shape_ok;
      bit          resp;
      got      = -1;
      got_rsp  = '0;
      shape_ok = 1'b1;
      cmd_stb  = 1'b1;
      cmd_word = mk_cmd(cmd_op_e'(op), pay);
      @(negedge clk);
      cmd_stb = 1'b0;
      for (int c = 0; c < 24; c++) begin
         if (rsp_stb) begin
            got     = c;
            got_rsp = rsp_word;
            if (o_wb_cyc !== 1'b0 || cmd_busy !== 1'b0) shape_ok = 1'b0;
            break;
         end
         if (o_wb_cyc !== (c < lat)) shape_ok = 1'b0;
         if (cmd_busy !== (c < lat)) shape_ok = 1'b0;
         if (o_wb_stb !== (c <= s && c < lat)) shape_ok = 1'b0;
         if (c == 0 && op[1] == 1'b0) begin
            chk({tag, " addr"}, 64'(o_wb_addr), 64'(ea));
            chk({tag, " we"}, 64'(o_wb_we), 64'(op[0]));
            if (op == 2'b01) chk({tag, " wdata"}, 64'(o_wb_data), 64'(pay));
         end
         i_wb_stall = (c < s);
         resp       = (kind != K_NONE) && (c == s + w);
         i_wb_ack   = resp && (kind != K_ERR);
         i_wb_err   = resp && (kind != K_ACK);
         i_wb_data  = (resp && kind == K_ACK) ? rd : $urandom;
         @(negedge clk);
      end
      i_wb_stall = 1'b0;
      i_wb_ack   = 1'b0;
      i_wb_err   = 1'b0;
      chk({tag, " latency"}, 64'(got), 64'(lat));
      chk({tag, " rsp"}, 64'(got_rsp), 64'(er));
      chk({tag, " bus shape"}, 64'(shape_ok), 64'd1);
      @(negedge clk);
      chk({tag, " rsp pulse"}, 64'(rsp_stb), 64'd0);
      chk({tag, " rsp hold"}, 64'(rsp_word), 64'(er));
   endtask

   task automatic model_and_run(input string tag, input logic [1:0] op, input logic [31:0] pay,
                                input int s, input int w, input int kind, input logic [31:0] rd);
      logic [29:0] ea;
      logic [33:0] er;
      int          lat;
      model_step(op, pay, s, w, kind, rd, ea, er, lat);
      run_cmd(tag, op, pay, s, w, kind, rd, ea, er, lat);
   endtask

   initial begin
      logic [29:0] ea;
      logic [33:0] er;
      int          lat;

      tbl[0]  = '{2'b10, 32'h4000_0010, 0, 0, K_ACK,  32'h0,         30'h0,        34'h2_0000_0010, 0};
      tbl[1]  = '{2'b00, 32'h0,         0, 1, K_ACK,  32'hDEADBEEF,  30'h10,       34'h0_DEADBEEF,  2};
      tbl[2]  = '{2'b00, 32'h0,         1, 0, K_ACK,  32'h12345678,  30'h10,       34'h0_12345678,  2};
      tbl[3]  = '{2'b10, 32'h0000_0020, 0, 0, K_ACK,  32'h0,         30'h0,        34'h2_0000_0020, 0};
      tbl[4]  = '{2'b01, 32'hCAFEF00D,  2, 1, K_ACK,  32'h0,         30'h20,       34'h1_0000_0000, 4};
      tbl[5]  = '{2'b01, 32'hCAFEF00D,  2, 1, K_ACK,  32'h0,         30'h21,       34'h1_0000_0000, 4};
      tbl[6]  = '{2'b01, 32'hCAFEF00D,  2, 1, K_ACK,  32'h0,         30'h22,       34'h1_0000_0000, 4};
      tbl[7]  = '{2'b10, 32'h3FFF_FFFF, 0, 0, K_ACK,  32'h0,         30'h0,        34'h2_3FFF_FFFF, 0};
      tbl[8]  = '{2'b00, 32'h0,         0, 1, K_ACK,  32'h11111111,  30'h3FFFFFFF, 34'h0_11111111,  2};
      tbl[9]  = '{2'b00, 32'h0,         0, 1, K_ACK,  32'h22222222,  30'h0,        34'h0_22222222,  2};
      tbl[10] = '{2'b00, 32'h0,         0, 2, K_ERR,  32'h0,         30'h1,        34'h3_0000_0000, 3};
      tbl[11] = '{2'b00, 32'h0,         1, 1, K_BOTH, 32'h0,         30'h1,        34'h3_0000_0000, 3};
      tbl[12] = '{2'b00, 32'h0,         0, 0, K_ACK,  32'hAAAA5555,  30'h1,        34'h0_AAAA5555,  1};
      tbl[13] = '{2'b11, 32'hFFFF_FFFF, 0, 0, K_ACK,  32'h0,         30'h0,        34'h3_0000_0000, 0};
      tbl[14] = '{2'b01, 32'h13579BDF,  0, 7, K_ACK,  32'h0,         30'h2,        34'h1_0000_0000, 8};
      tbl[15] = '{2'b00, 32'h0,         0, 8, K_ACK,  32'h0,         30'h3,        34'h3_0000_0001, 8};
      tbl[16] = '{2'b00, 32'h0,         0, 1, K_ACK,  32'h0BADF00D,  30'h3,        34'h0_0BADF00D,  2};

      reset      = 1'b0;
      cmd_stb    = 1'b0;
      cmd_word   = '0;
      i_wb_stall = 1'b0;
      i_wb_ack   = 1'b0;
      i_wb_err   = 1'b0;
      i_wb_data  = '0;
      m_addr     = '0;
      m_inc      = 1'b1;

      #12;
      chk("reset cyc",  64'(o_wb_cyc),  64'd0);
      chk("reset stb",  64'(o_wb_stb),  64'd0);
      chk("reset we",   64'(o_wb_we),   64'd0);
      chk("reset addr", 64'(o_wb_addr), 64'd0);
      chk("reset data", 64'(o_wb_data), 64'd0);
      chk("reset sel",  64'(o_wb_sel),  64'hF);
      chk("reset busy", 64'(cmd_busy),  64'd0);
      chk("reset rsp",  64'({rsp_stb, rsp_word}), 64'd0);
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);

      for (int i = 0; i < 17; i++) begin
         model_step(tbl[i].op, tbl[i].pay, tbl[i].s, tbl[i].w, tbl[i].kind, tbl[i].rd, ea, er, lat);
         run_cmd($sformatf("vec%0d", i), tbl[i].op, tbl[i].pay, tbl[i].s, tbl[i].w,
                 tbl[i].kind, tbl[i].rd, tbl[i].addr, tbl[i].rsp, tbl[i].lat);
      end

      // A late ack after the watchdog fired must not produce a response.
      model_and_run("timeout", 2'b00, 32'h0, 0, 0, K_NONE, 32'h0);
      @(negedge clk);
      i_wb_ack  = 1'b1;
      i_wb_data = 32'h5555AAAA;
      @(negedge clk);
      i_wb_ack = 1'b0;
      for (int k = 0; k < 3; k++) begin
         chk("late ack rsp_stb", 64'(rsp_stb), 64'd0);
         chk("late ack cyc", 64'(o_wb_cyc), 64'd0);
         @(negedge clk);
      end
      chk("late ack rsp hold", 64'(rsp_word), 64'h3_0000_0001);

      // Back-to-back SETADDR with cmd_stb held high.
      cmd_stb  = 1'b1;
      cmd_word = mk_cmd(CMD_ADDR, 32'h0000_0100);
      @(negedge clk);
      chk("b2b rsp1", 64'({rsp_stb, cmd_busy, rsp_word}), {28'h0, 2'b10, 34'h2_0000_0100});
      cmd_word = mk_cmd(CMD_ADDR, 32'h4000_0200);
      @(negedge clk);
      chk("b2b rsp2", 64'({rsp_stb, rsp_word}), {29'h0, 1'b1, 34'h2_0000_0200});
      cmd_stb = 1'b0;
      m_addr  = 30'h200;
      m_inc   = 1'b0;
      @(negedge clk);
      model_and_run("b2b read", 2'b00, 32'h0, 0, 1, K_ACK, 32'h600DCAFE);

      for (int i = 0; i < 250; i++) begin
         int          r;
         int          k;
         logic [1:0]  op;
         logic [31:0] pay;
         int          kind;
         r   = $urandom_range(0, 99);
         op  = (r < 40) ? 2'b00 : (r < 75) ? 2'b01 : (r < 90) ? 2'b10 : 2'b11;
         pay = $urandom;
         if (op == 2'b10 && $urandom_range(0, 3) == 0)
            pay[29:0] = 30'h3FFFFFFD + 30'($urandom_range(0, 2));
         k    = $urandom_range(0, 19);
         kind = (k < 14) ? K_ACK : (k < 16) ? K_ERR : (k < 18) ? K_BOTH : K_NONE;
         model_and_run($sformatf("rnd%0d", i), op, pay, $urandom_range(0, 3),
                       $urandom_range(0, 5), kind, $urandom);
      end

      // Reset pulled low while the master sits in WAIT.
      cmd_stb  = 1'b1;
      cmd_word = mk_cmd(CMD_RD, 32'h0);
      @(negedge clk);
      cmd_stb = 1'b0;
      @(negedge clk);
      chk("pre-reset wait cyc", 64'({o_wb_cyc, o_wb_stb}), 64'b10);
      #2;
      reset = 1'b0;
      #1;
      chk("async reset outputs", 64'({o_wb_cyc, o_wb_stb, cmd_busy, rsp_stb}), 64'd0);
      @(negedge clk);
      reset  = 1'b1;
      m_addr = '0;
      m_inc  = 1'b1;
      @(negedge clk);
      chk("post-reset no rsp", 64'({rsp_stb, o_wb_cyc}), 64'd0);
      model_and_run("post-reset read0", 2'b00, 32'h0, 0, 1, K_ACK, 32'h01020304);
      model_and_run("post-reset setaddr", 2'b10, 32'h0000_0005, 0, 0, K_ACK, 32'h0);
      model_and_run("post-reset read5", 2'b00, 32'h0, 1, 1, K_ACK, 32'hFEEDFACE);
      model_and_run("post-reset read6", 2'b00, 32'h0, 0, 1, K_ACK, 32'h0F0F0F0F);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
